sr_event_gen: RTL and testbench



---
 rtl/sr_pkg.sv | 18 +
 rtl/sr_debounce.sv | 55 +++++
 rtl/sr_event_gen.sv | 72 +++++++
 tb/tb_sr_event_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared constants and helpers for the set/reset event front-end.
package sr_pkg;

    localparam int SYNC_STAGES   = 2;
    localparam int DB_CYCLES_DEF = 4;
    localparam int HOLDOFF_DEF   = 8;

    // Width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// One input channel: synchroniser, debounce filter and rising-edge request.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic rise
);

    localparam int                CNT_W    = clog2_min1(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p0;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   f_p1;
    logic                   flip;

    // Stage p0: metastability synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
        end
    end

    assign s_p0 = sync_p0[SYNC_STAGES-1];
    assign flip = (s_p0 != f_p1) && (cnt_p1 == CNT_LAST);

    // Stage p1: debounce filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
            f_p1   <= 1'b0;
        end else if (s_p0 == f_p1) begin
            cnt_p1 <= '0;
        end else if (flip) begin
            f_p1   <= s_p0;
            cnt_p1 <= '0;
        end else begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign lvl = f_p1;
    // Request for the edge at which the filtered level goes 0->1; the
    // parent registers it on that same edge.
    assign rise = flip & s_p0;

endmodule

// File: rtl/sr_event_gen.sv
// Event front-end: two debounced channels plus clear-over-set arbitration and set hold-off.
module sr_event_gen
    import sr_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int HOLDOFF   = HOLDOFF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic trig_raw,
    input  logic clr_raw,
    output logic E0,
    output logic E1,
    output logic drop,
    output logic trig_lvl,
    output logic clr_lvl
);

    localparam int               HC_W      = clog2_min1(HOLDOFF + 1);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLDOFF);

    logic            trig_req;
    logic            clr_req;
    logic [HC_W-1:0] hcnt_p2;
    logic            set_ok;
    logic            set_drop;
    logic            clr_ok;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_trig (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (trig_raw),
        .lvl  (trig_lvl),
        .rise (trig_req)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (clr_raw),
        .lvl  (clr_lvl),
        .rise (clr_req)
    );

    // A set loses to a simultaneous clear or an active hold-off; both count as drops.
    always_comb begin
        set_ok   = en & trig_req & ~clr_req & (hcnt_p2 == '0);
        set_drop = en & trig_req & (clr_req | (hcnt_p2 != '0));
        clr_ok   = en & clr_req;
    end

    // Stage p2: registered event pulses and hold-off counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E0      <= 1'b0;
            E1      <= 1'b0;
            drop    <= 1'b0;
            hcnt_p2 <= '0;
        end else begin
            E0   <= set_ok;
            E1   <= clr_ok;
            drop <= set_drop;
            if (set_ok) begin
                hcnt_p2 <= HOLD_LOAD;
            end else if (hcnt_p2 != '0) begin
                hcnt_p2 <= hcnt_p2 - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_event_gen.sv
// Scoreboard bench for sr_event_gen: default instance plus a long hold-off instance.
module tb_sr_event_gen;

    logic clk = 1'b0;
    logic rst_n, en;
    logic trig_a, clr_a, trig_b, clr_b;
    logic e0_a, e1_a, drop_a, tlvl_a, clvl_a;
    logic e0_b, e1_b, drop_b, tlvl_b, clvl_b;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        int         cyc;
        logic [2:0] flg;
    } ev_t;

    localparam logic [2:0] F_E0   = 3'b100;
    localparam logic [2:0] F_E1   = 3'b010;
    localparam logic [2:0] F_DROP = 3'b001;

    ev_t qa[$];
    ev_t qb[$];
    ev_t ev_a, ev_b;

    sr_event_gen #(.DB_CYCLES(4), .HOLDOFF(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .trig_raw(trig_a), .clr_raw(clr_a),
        .E0(e0_a), .E1(e1_a), .drop(drop_a), .trig_lvl(tlvl_a), .clr_lvl(clvl_a)
    );

    sr_event_gen #(.DB_CYCLES(2), .HOLDOFF(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .trig_raw(trig_b), .clr_raw(clr_b),
        .E0(e0_b), .E1(e1_b), .drop(drop_b), .trig_lvl(tlvl_b), .clr_lvl(clvl_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push_a(input int c, input logic [2:0] f);
        ev_t e;
        e.cyc = c;
        e.flg = f;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [2:0] f);
        ev_t e;
        e.cyc = c;
        e.flg = f;
        qb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (e0_a | e1_a | drop_a) begin
            check("a_excl", int'(e0_a & e1_a), 0);
            if (qa.size() == 0) begin
                check("a_unexpected", int'({e0_a, e1_a, drop_a}), 0);
            end else begin
                ev_a = qa.pop_front();
                check("a_cycle", cyc, ev_a.cyc);
                check("a_flags", int'({e0_a, e1_a, drop_a}), int'(ev_a.flg));
            end
        end
    end

    always @(negedge clk) begin
        if (e0_b | e1_b | drop_b) begin
            check("b_excl", int'(e0_b & e1_b), 0);
            if (qb.size() == 0) begin
                check("b_unexpected", int'({e0_b, e1_b, drop_b}), 0);
            end else begin
                ev_b = qb.pop_front();
                check("b_cycle", cyc, ev_b.cyc);
                check("b_flags", int'({e0_b, e1_b, drop_b}), int'(ev_b.flg));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_off[6];
        int s_base;
        int tgt;
        int last_acc;

        rst_n  = 1'b0;
        en     = 1'b1;
        trig_a = 1'b0;
        clr_a  = 1'b0;
        trig_b = 1'b0;
        clr_b  = 1'b0;
        tick(3);
        check("rst_e0",   e0_a,   0);
        check("rst_e1",   e1_a,   0);
        check("rst_drop", drop_a, 0);
        check("rst_tlvl", tlvl_a, 0);
        check("rst_clvl", clvl_a, 0);
        check("rst_b_lvl", int'({tlvl_b, clvl_b, e0_b}), 0);
        rst_n = 1'b1;
        tick(2);

        // Clean trigger, then release
        trig_a = 1'b1;
        push_a(cyc + 6, F_E0);
        tick(5);
        check("clean_lvl_pre", tlvl_a, 0);
        tick(1);
        check("clean_lvl", tlvl_a, 1);
        tick(10);
        trig_a = 1'b0;
        tick(5);
        check("fall_lvl_pre", tlvl_a, 1);
        tick(1);
        check("fall_lvl", tlvl_a, 0);
        tick(10);

        // Bounce: 3 high, 1 low, then steady high
        trig_a = 1'b1;
        push_a(cyc + 10, F_E0);
        tick(3);
        trig_a = 1'b0;
        tick(1);
        trig_a = 1'b1;
        tick(5);
        check("bounce_lvl_pre", tlvl_a, 0);
        tick(1);
        check("bounce_lvl", tlvl_a, 1);
        tick(10);
        trig_a = 1'b0;
        tick(15);

        // Collision: clear wins, set dropped
        trig_a = 1'b1;
        clr_a  = 1'b1;
        push_a(cyc + 6, F_E1 | F_DROP);
        tick(6);
        check("coll_tlvl", tlvl_a, 1);
        check("coll_clvl", clvl_a, 1);
        tick(5);
        trig_a = 1'b0;
        clr_a  = 1'b0;
        tick(15);

        // Disabled: levels track, no pulses
        en     = 1'b0;
        trig_a = 1'b1;
        clr_a  = 1'b1;
        tick(6);
        check("en0_tlvl", tlvl_a, 1);
        check("en0_clvl", clvl_a, 1);
        tick(4);
        trig_a = 1'b0;
        clr_a  = 1'b0;
        tick(6);
        check("en0_tlvl_fall", tlvl_a, 0);
        check("en0_clvl_fall", clvl_a, 0);
        tick(4);
        en = 1'b1;
        tick(5);

        // Reset in the middle of a trigger count, with clear level high
        clr_a = 1'b1;
        push_a(cyc + 6, F_E1);
        tick(10);
        trig_a = 1'b1;
        tick(4);
        #2;
        rst_n = 1'b0;
        clr_a = 1'b0;
        #1;
        check("arst_clvl", clvl_a, 0);
        check("arst_tlvl", tlvl_a, 0);
        check("arst_pulses", int'({e0_a, e1_a, drop_a}), 0);
        tick(2);
        rst_n = 1'b1;
        push_a(cyc + 6, F_E0);
        tick(5);
        check("post_rst_lvl_pre", tlvl_a, 0);
        tick(1);
        check("post_rst_lvl", tlvl_a, 1);
        tick(5);
        trig_a = 1'b0;
        tick(12);

        // Hold-off window on the DB_CYCLES=2, HOLDOFF=20 instance
        req_off  = '{0, 10, 25, 45, 55, 76};
        s_base   = cyc + 10;
        last_acc = -1000;
        for (int i = 0; i < 6; i++) begin
            tgt = s_base + req_off[i];
            while (cyc < tgt - 4) tick(1);
            trig_b = 1'b1;
            if (tgt - last_acc <= 20) begin
                push_b(tgt, F_DROP);
            end else begin
                push_b(tgt, F_E0);
                last_acc = tgt;
            end
            tick(5);
            trig_b = 1'b0;
        end
        tick(20);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
